// File: rtl/vblank_write_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter that shares one RAM write port between N_REQ requesters,
// issuing writes only inside the vertical blanking window.
module vblank_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 12,
  parameter int LAST_LINE = 803
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    vblnk,
  input  logic [10:0]             vcount,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_data,
  output logic                    win_open,
  output logic [7:0]              miss_cnt
);

  localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [10:0] LAST_LINE_V = 11'(LAST_LINE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    CLOSED = 2'd2
  } state_t;

  state_t            state_q;
  logic              vblnkPrev_q;
  logic              armed_q;
  logic [RR_W-1:0]   rr_q;
  logic [RR_W-1:0]   rr_d;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  gnt_d;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [ADDR_W-1:0] memAddr_d;
  logic [DATA_W-1:0] memData_q;
  logic [DATA_W-1:0] memData_d;
  logic              winOpen_q;
  logic [7:0]        missCnt_q;

  logic [N_REQ-1:0]  eligible;
  logic              anyEligible;
  logic [RR_W-1:0]   winner;
  logic [RR_W-1:0]   idx;
  logic              vblnkRise;
  logic              pastLast;
  logic              closeNow;

  // armed_q blocks a window opening when reset releases in the middle of a blank
  assign vblnkRise = vblnk & ~vblnkPrev_q & armed_q;
  assign pastLast  = (vcount > LAST_LINE_V);
  assign closeNow  = pastLast | ~vblnk;

  // Scan offsets from the highest down so the one closest to rr wins last
  always_comb begin
    eligible    = req & ~gnt_q;
    anyEligible = 1'b0;
    winner      = '0;
    idx         = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = RR_W'((int'(rr_q) + k) % N_REQ);
      if (eligible[idx]) begin
        anyEligible = 1'b1;
        winner      = idx;
      end
    end
    rr_d      = (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
    gnt_d     = '0;
    memAddr_d = req_addr[ADDR_W-1:0];
    memData_d = req_data[DATA_W-1:0];
    for (int k = 0; k < N_REQ; k++) begin
      if (winner == RR_W'(k)) begin
        gnt_d[k]  = anyEligible;
        memAddr_d = req_addr[k*ADDR_W +: ADDR_W];
        memData_d = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      vblnkPrev_q <= 1'b0;
      armed_q     <= 1'b0;
      rr_q        <= '0;
      gnt_q       <= '0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memData_q   <= '0;
      winOpen_q   <= 1'b0;
      missCnt_q   <= '0;
    end else begin
      vblnkPrev_q <= vblnk;
      if (!vblnk) begin
        armed_q <= 1'b1;
      end
      gnt_q   <= '0;
      memWe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vblnkRise && !pastLast) begin
            state_q   <= WINDOW;
            winOpen_q <= 1'b1;
          end
        end
        WINDOW: begin
          if (closeNow) begin
            state_q   <= CLOSED;
            winOpen_q <= 1'b0;
            if (|req && missCnt_q != 8'hFF) begin
              missCnt_q <= missCnt_q + 8'd1;
            end
          end else if (anyEligible) begin
            gnt_q     <= gnt_d;
            memWe_q   <= 1'b1;
            memAddr_q <= memAddr_d;
            memData_q <= memData_d;
            rr_q      <= rr_d;
          end
        end
        CLOSED: begin
          if (!vblnk) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          winOpen_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign mem_we   = memWe_q;
  assign mem_addr = memAddr_q;
  assign mem_data = memData_q;
  assign win_open = winOpen_q;
  assign miss_cnt = missCnt_q;

endmodule
